pb_timer_ctrl: RTL and testbench
================================

Name: pb_timer_ctrl

Overview:
PicoBlaze port-mapped controller that drives the CE/CLR inputs of a simple_timer instance and consumes its OUT (done) level. It contains a programmable prescaler that generates single-cycle CE strobes, a run/stop state machine, and a sticky done flag with an acknowledged interrupt. It sits between the PicoBlaze port bus and the timer core.

Parameters:
BASE_ADDR, 8'h00, PicoBlaze port base; the block decodes PORT_ID[7:2] == BASE_ADDR[7:2].
PRESCALE_BITS, 16, prescaler width; a value of P produces one CE every P+1 clocks.
DEFAULT_PRESCALE, 0, reset value of the PRESCALE register.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST_N  in  1  asynchronous active-low reset.
PORT_ID  in  8  PicoBlaze port address.
WRITE_STROBE  in  1  PicoBlaze write strobe.
READ_STROBE  in  1  PicoBlaze read strobe; informational, reads have no side effects.
OUT_PORT  in  8  PicoBlaze write data.
IN_PORT  out  8  registered read data.
INTERRUPT  out  1  interrupt request to PicoBlaze.
INTERRUPT_ACK  in  1  PicoBlaze interrupt acknowledge.
TIMER_CE  out  1  to the timer CE input.
TIMER_CLR  out  1  to the timer CLR input.
TIMER_DONE  in  1  from the timer OUT (level).

Behaviour:
- Reset (RST_N=0, async): state IDLE, CTRL=0, PRESCALE=DEFAULT_PRESCALE, DONE=0, INTERRUPT=0, TIMER_CE=0, TIMER_CLR=1, IN_PORT=0, prescaler=0.
- Register map (PORT_ID[1:0]):
  - 0 CTRL (R/W): bit0 RUN, bit1 PERIODIC, bit2 IRQ_EN.
  - 1 PRESCALE[7:0] (R/W).
  - 2 PRESCALE[15:8] (R/W). Bits at or above PRESCALE_BITS are ignored on write and read as 0.
  - 3 STATUS: bit0 DONE (sticky), bit1 RUNNING (state is CLEAR or COUNT). Writing 1 to bit0 clears DONE and deasserts INTERRUPT.
- IN_PORT updates every clock from the PORT_ID decode (one-cycle latency). It reads 0 when the address does not match.
- FSM states:
  - IDLE: TIMER_CLR=1, TIMER_CE=0. A write to CTRL with RUN=1 moves to CLEAR.
  - CLEAR (exactly 1 cycle): TIMER_CLR=1, TIMER_CE=0. Prescaler is set to 0 and the active prescale is loaded from PRESCALE. Next state is COUNT. TIMER_DONE is ignored in this state.
  - COUNT: TIMER_CLR=0. The prescaler increments each cycle. When prescaler == active prescale, TIMER_CE=1 for one cycle, the prescaler wraps to 0, and the active prescale reloads from PRESCALE. With PRESCALE=0, CE is high every cycle.
    - If TIMER_DONE=1 in COUNT: that cycle's CE is suppressed, DONE is set, and INTERRUPT is set if IRQ_EN=1.
    - Then, if PERIODIC=1, go to CLEAR. Otherwise go to EXPIRED and clear CTRL.RUN.
  - EXPIRED: TIMER_CLR=0, TIMER_CE=0, so the timer holds its done level. A write to CTRL with RUN=1 moves to CLEAR.
- A CTRL write with RUN=0 in any state moves to IDLE on the next clock. The done event is not generated in that cycle.
- A CTRL write with RUN=1 while in CLEAR or COUNT restarts via CLEAR.
- INTERRUPT clears on INTERRUPT_ACK=1 or on a STATUS W1C. A done event in the same cycle as ack or W1C wins: INTERRUPT and DONE stay 1.
- Writing IRQ_EN=0 does not drop a pending INTERRUPT.
- Timer COUNT=0 (TIMER_DONE constantly high): the block expires on the first COUNT cycle. In periodic mode it alternates CLEAR/COUNT, raising the done event every 2 cycles.
- PRESCALE writes during COUNT take effect at the next CE wrap or CLEAR, never mid-period.

Optional Feature:
- Macro: PB_TIMER_OVERRUN_EN.
- Defined: STATUS bit2 is OVERRUN. It is set when a done event occurs while DONE is already 1. It is cleared by writing 1 to STATUS bit2, and shares the same precedence rule (a new event beats the clear).
- Undefined: no OVERRUN logic is built and STATUS bit2 reads 0.

Test Plan:
- Reset: assert RST_N=0 mid-COUNT → outputs immediately TIMER_CLR=1, TIMER_CE=0, INTERRUPT=0; after release, STATUS reads 8'h00.
- One-shot: timer COUNT=4, PRESCALE=2, CTRL=8'h05 → CE pulses every 3rd cycle. After the 4th CE, TIMER_DONE=1, then DONE=1, INTERRUPT=1, state EXPIRED, CTRL reads 8'h04.
- Periodic with ack: timer COUNT=3, PRESCALE=0, CTRL=8'h07 → done event every 5 cycles (1 CLEAR + 4 COUNT). INTERRUPT_ACK pulse clears INTERRUPT; the next event re-asserts it.
- Simultaneous: done event in the same cycle as INTERRUPT_ACK → INTERRUPT remains 1 and DONE remains 1.
- Stop/prescale: write PRESCALE=5 mid-period with PRESCALE=1 active → the current period keeps 2-cycle CE spacing, then 6-cycle spacing. A CTRL=0 write → IDLE, TIMER_CLR=1 next clock.
- Overrun (macro defined): two periodic events without a W1C → STATUS=8'h07; writing 8'h05 to STATUS → STATUS=8'h02 while running.

Source files
------------

// File: rtl/pb_timer_ctrl.sv
// PicoBlaze port-mapped controller for a simple_timer: prescaled CE strobes, run/stop FSM,
// sticky DONE with acknowledged interrupt. Define PB_TIMER_OVERRUN_EN to build the STATUS OVERRUN bit.
module pb_timer_ctrl #(
  parameter logic [7:0]  BASE_ADDR        = 8'h00,
  parameter int unsigned PRESCALE_BITS    = 16,
  parameter int unsigned DEFAULT_PRESCALE = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PORT_ID,
  input  logic       WRITE_STROBE,
  input  logic       READ_STROBE,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_PORT,
  output logic       INTERRUPT,
  input  logic       INTERRUPT_ACK,
  output logic       TIMER_CE,
  output logic       TIMER_CLR,
  input  logic       TIMER_DONE
);

  localparam int unsigned PB = PRESCALE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_COUNT   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [PB-1:0] prescale_q, prescale_d;
  logic [PB-1:0] active_q, active_d;
  logic [PB-1:0] presc_cnt_q, presc_cnt_d;
  logic          done_q, done_d;
  logic          irq_q, irq_d;
  logic [7:0]    in_port_q, in_port_d;
  logic          ovr_q, ovr_d;

  logic          sel_c, wr_ctrl_c, wr_lo_c, wr_hi_c, wr_stat_c, stop_wr_c;
  logic          ce_c, clr_c, done_evt_c, running_c;
  logic [15:0]   presc_wide_c, presc_wr_c;

  // Reads are side-effect free, so the strobe only marks bus activity.
  logic unused_read_strobe;
  assign unused_read_strobe = READ_STROBE;

  assign sel_c     = (PORT_ID[7:2] == BASE_ADDR[7:2]);
  assign wr_ctrl_c = WRITE_STROBE && sel_c && (PORT_ID[1:0] == 2'd0);
  assign wr_lo_c   = WRITE_STROBE && sel_c && (PORT_ID[1:0] == 2'd1);
  assign wr_hi_c   = WRITE_STROBE && sel_c && (PORT_ID[1:0] == 2'd2);
  assign wr_stat_c = WRITE_STROBE && sel_c && (PORT_ID[1:0] == 2'd3);
  assign stop_wr_c = wr_ctrl_c && !OUT_PORT[0];
  assign running_c = (state_q == ST_CLEAR) || (state_q == ST_COUNT);

  assign presc_wide_c = 16'(prescale_q);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    active_d    = active_q;
    presc_cnt_d = presc_cnt_q;
    done_d      = done_q;
    irq_d       = irq_q;
    ovr_d       = ovr_q;
    in_port_d   = 8'h00;
    ce_c        = 1'b0;
    clr_c       = 1'b0;
    done_evt_c  = 1'b0;
    presc_wr_c  = presc_wide_c;

    unique case (state_q)
      ST_IDLE: clr_c = 1'b1;
      ST_CLEAR: begin
        clr_c       = 1'b1;
        presc_cnt_d = '0;
        active_d    = prescale_q;
        state_d     = ST_COUNT;
      end
      ST_COUNT: begin
        if (presc_cnt_q == active_q) begin
          presc_cnt_d = '0;
          active_d    = prescale_q;
          ce_c        = !TIMER_DONE;
        end else begin
          presc_cnt_d = presc_cnt_q + PB'(1);
        end
        if (TIMER_DONE) begin
          done_evt_c = !stop_wr_c;
          if (ctrl_q[1]) begin
            state_d = ST_CLEAR;
          end else begin
            state_d   = ST_EXPIRED;
            ctrl_d[0] = 1'b0;
          end
        end
      end
      ST_EXPIRED: ;
      default: state_d = ST_IDLE;
    endcase

    // Bus writes override the FSM's own transition in the same cycle.
    if (wr_ctrl_c) begin
      ctrl_d  = OUT_PORT[2:0];
      state_d = OUT_PORT[0] ? ST_CLEAR : ST_IDLE;
    end
    if (wr_lo_c) presc_wr_c[7:0] = OUT_PORT;
    if (wr_hi_c) presc_wr_c[15:8] = OUT_PORT;
    if (wr_lo_c || wr_hi_c) prescale_d = PB'(presc_wr_c);

    // A done event beats a same-cycle clear.
    if (done_evt_c) done_d = 1'b1;
    else if (wr_stat_c && OUT_PORT[0]) done_d = 1'b0;

    if (done_evt_c && ctrl_q[2]) irq_d = 1'b1;
    else if (INTERRUPT_ACK || (wr_stat_c && OUT_PORT[0])) irq_d = 1'b0;

`ifdef PB_TIMER_OVERRUN_EN
    if (done_evt_c && done_q) ovr_d = 1'b1;
    else if (wr_stat_c && OUT_PORT[2]) ovr_d = 1'b0;
`else
    ovr_d = 1'b0;
`endif

    if (sel_c) begin
      unique case (PORT_ID[1:0])
        2'd0: in_port_d = {5'b0, ctrl_q};
        2'd1: in_port_d = presc_wide_c[7:0];
        2'd2: in_port_d = presc_wide_c[15:8];
        2'd3: in_port_d = {5'b0, ovr_q, running_c, done_q};
        default: in_port_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 3'b000;
      prescale_q  <= PB'(DEFAULT_PRESCALE);
      active_q    <= PB'(DEFAULT_PRESCALE);
      presc_cnt_q <= '0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      ovr_q       <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      active_q    <= active_d;
      presc_cnt_q <= presc_cnt_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      ovr_q       <= ovr_d;
      in_port_q   <= in_port_d;
    end
  end

  // CE must drop in the very cycle TIMER_DONE rises, so timer strobes decode from current state.
  assign TIMER_CE  = ce_c;
  assign TIMER_CLR = clr_c;
  assign IN_PORT   = in_port_q;
  assign INTERRUPT = irq_q;

endmodule

// File: tb/tb_pb_timer_ctrl.sv
// Scoreboard bench for pb_timer_ctrl: a behavioural model with an attached timer predicts
// per-cycle CE/CLR/INTERRUPT and read data; a monitor process pops and compares.
module tb_pb_timer_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] PORT_ID = 8'hFC;
  logic       WRITE_STROBE = 1'b0;
  logic       READ_STROBE = 1'b0;
  logic [7:0] OUT_PORT = 8'h00;
  logic [7:0] IN_PORT;
  logic       INTERRUPT;
  logic       INTERRUPT_ACK = 1'b0;
  logic       TIMER_CE;
  logic       TIMER_CLR;
  logic       TIMER_DONE = 1'b0;

  always #5 CLK = ~CLK;

  pb_timer_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .PORT_ID(PORT_ID), .WRITE_STROBE(WRITE_STROBE),
    .READ_STROBE(READ_STROBE), .OUT_PORT(OUT_PORT), .IN_PORT(IN_PORT),
    .INTERRUPT(INTERRUPT), .INTERRUPT_ACK(INTERRUPT_ACK), .TIMER_CE(TIMER_CE),
    .TIMER_CLR(TIMER_CLR), .TIMER_DONE(TIMER_DONE)
  );

  typedef struct packed {
    logic ce;
    logic clr;
    logic irq;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] rd_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model: mode 0 stopped, 1 clearing, 2 counting, 3 expired; m_wait = cycles left before next CE.
  int         m_mode;
  logic [2:0] m_ctrl;
  logic [15:0] m_presc;
  int         m_wait;
  logic       m_done, m_irq, m_ovr;
  int         t_cnt, t_count;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ctrl = 3'b0; m_presc = 16'h0; m_wait = 0;
    m_done = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; t_cnt = 0;
  endtask

  // One bus cycle: called just after a falling edge, returns at the next falling edge.
  task automatic step(input bit wr, input bit rd, input logic [7:0] addr,
                      input logic [7:0] data, input bit ack);
    logic tdone, ce_e, clr_e, sel, wr_ctrl, stop, w1c, evt, old_done, irq_en, periodic;
    logic [15:0] old_presc;
    logic [7:0] rv;
    cyc_t e;
    int a;
    tdone = (t_cnt >= t_count);
    TIMER_DONE = tdone; WRITE_STROBE = wr; READ_STROBE = rd;
    PORT_ID = addr; OUT_PORT = data; INTERRUPT_ACK = ack;
    clr_e = (m_mode == 0) || (m_mode == 1);
    ce_e  = (m_mode == 2) && (m_wait == 0) && !tdone;
    e.ce = ce_e; e.clr = clr_e; e.irq = m_irq;
    cyc_q.push_back(e);
    sel = (addr[7:2] == 6'd0);
    a = int'(addr[1:0]);
    if (rd) begin
      rv = 8'h00;
      if (sel) begin
        case (a)
          0: rv = {5'b0, m_ctrl};
          1: rv = m_presc[7:0];
          2: rv = m_presc[15:8];
          default: rv = {5'b0, m_ovr, (m_mode == 1 || m_mode == 2), m_done};
        endcase
      end
      rd_q.push_back(rv);
    end
    @(posedge CLK);
    wr_ctrl   = wr && sel && (a == 0);
    stop      = wr_ctrl && !data[0];
    w1c       = wr && sel && (a == 3);
    evt       = (m_mode == 2) && tdone && !stop;
    old_done  = m_done;
    irq_en    = m_ctrl[2];
    periodic  = m_ctrl[1];
    old_presc = m_presc;
    if (clr_e) t_cnt = 0;
    else if (ce_e) t_cnt++;
    if (m_mode == 1) begin
      m_mode = 2; m_wait = int'(old_presc);
    end else if (m_mode == 2) begin
      if (m_wait == 0) m_wait = int'(old_presc);
      else m_wait--;
      if (tdone) begin
        if (periodic) m_mode = 1;
        else begin m_mode = 3; m_ctrl[0] = 1'b0; end
      end
    end
    if (wr_ctrl) begin
      m_ctrl = data[2:0];
      m_mode = data[0] ? 1 : 0;
    end
    if (wr && sel && a == 1) m_presc[7:0] = data;
    if (wr && sel && a == 2) m_presc[15:8] = data;
    if (evt) m_done = 1'b1;
    else if (w1c && data[0]) m_done = 1'b0;
    if (evt && irq_en) m_irq = 1'b1;
    else if (ack || (w1c && data[0])) m_irq = 1'b0;
`ifdef PB_TIMER_OVERRUN_EN
    if (evt && old_done) m_ovr = 1'b1;
    else if (w1c && data[2]) m_ovr = 1'b0;
`endif
    @(negedge CLK);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'hFC, 8'h00, 1'b0);
  endtask
  task automatic wreg(input logic [7:0] addr, input logic [7:0] data);
    step(1'b1, 1'b0, addr, data, 1'b0);
  endtask
  task automatic rreg(input logic [7:0] addr);
    step(1'b0, 1'b1, addr, 8'h00, 1'b0);
  endtask

  // Monitor: compares strobes every cycle and read data one cycle after a read.
  initial begin
    bit rd_pend;
    cyc_t e;
    logic [7:0] exp_rd;
    rd_pend = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (!RST_N) begin
        rd_pend = 1'b0;
        continue;
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
        else begin
          exp_rd = rd_q.pop_front();
          check("in_port", 32'(IN_PORT), 32'(exp_rd));
        end
      end
      rd_pend = READ_STROBE;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("timer_ce", 32'(TIMER_CE), 32'(e.ce));
        check("timer_clr", 32'(TIMER_CLR), 32'(e.clr));
        check("interrupt", 32'(INTERRUPT), 32'(e.irq));
      end
    end
  end

  initial begin
    int r;
    model_reset();
    t_count = 4;
    #3;
    check("rst_clr", 32'(TIMER_CLR), 32'd1);
    check("rst_ce", 32'(TIMER_CE), 32'd0);
    check("rst_irq", 32'(INTERRUPT), 32'd0);
    check("rst_in_port", 32'(IN_PORT), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    rreg(8'h03); rreg(8'h00); rreg(8'h01); rreg(8'h07);
    // One-shot: 4 timer counts, CE every 3rd clock, IRQ enabled.
    wreg(8'h01, 8'h02); wreg(8'h00, 8'h05);
    idle(20);
    rreg(8'h00); rreg(8'h03);
    wreg(8'h03, 8'h01); rreg(8'h03);
    // Periodic, PRESCALE=0, timer count 3; ack held across several events.
    t_count = 3;
    wreg(8'h01, 8'h00); wreg(8'h00, 8'h07);
    idle(8);
    repeat (12) step(1'b0, 1'b0, 8'hFC, 8'h00, 1'b1);
    idle(6);
    step(1'b0, 1'b0, 8'hFC, 8'h00, 1'b1);
    idle(8);
    rreg(8'h03);
    // Prescale change mid-period, then stop.
    t_count = 30;
    wreg(8'h03, 8'h05); wreg(8'h01, 8'h01); wreg(8'h00, 8'h01);
    idle(4);
    wreg(8'h01, 8'h05);
    idle(16);
    rreg(8'h01);
    wreg(8'h00, 8'h00);
    idle(3);
    // Timer count 0: expire immediately, then periodic every 2 cycles.
    t_count = 0;
    wreg(8'h00, 8'h05); idle(4); rreg(8'h00);
    wreg(8'h00, 8'h07); idle(8);
    // Overrun: two periodic events without clearing.
    t_count = 1;
    wreg(8'h03, 8'h05); wreg(8'h00, 8'h03);
    idle(10);
    rreg(8'h03);
    wreg(8'h03, 8'h05);
    rreg(8'h03);
    idle(2);
    // High byte write and readback.
    wreg(8'h02, 8'hA5); rreg(8'h02); wreg(8'h02, 8'h00);
    // Asynchronous reset mid-count.
    t_count = 30;
    wreg(8'h00, 8'h05); idle(4);
    RST_N = 1'b0;
    #1;
    check("amid_clr", 32'(TIMER_CLR), 32'd1);
    check("amid_ce", 32'(TIMER_CE), 32'd0);
    check("amid_irq", 32'(INTERRUPT), 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    rreg(8'h03); rreg(8'h00);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) t_count = $urandom_range(0, 5);
      r = $urandom_range(0, 99);
      if (r < 2)
        wreg(8'h00, 8'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                                   : ($urandom_range(0, 255) | 1)));
      else if (r < 5) wreg(8'h01, 8'($urandom_range(0, 3)));
      else if (r < 6) wreg(8'h02, 8'(($urandom_range(0, 7) == 0) ? 1 : 0));
      else if (r < 9) wreg(8'h03, 8'($urandom_range(0, 255)));
      else if (r < 20) rreg(8'($urandom_range(0, 7)));
      else if (r < 25) step(1'b0, 1'b0, 8'hFC, 8'h00, 1'b1);
      else idle(1);
    end
    idle(3);
    check("drain", 32'(cyc_q.size() + rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
